// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the push-button LED sequencer.
// Width helpers stay function-based so each instance sizes from its own parameters.
package led_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  localparam int unsigned MIN_CNT_W = 1;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? MIN_CNT_W : $clog2(n);
  endfunction

  function automatic int pos_width(input int unsigned num_leds);
    return cnt_width(num_leds);
  endfunction

  // Active-low drive for channel ch: low only for the lit channel while running.
  function automatic logic led_bit(input logic run, input int unsigned idx,
                                   input int unsigned ch);
    return !(run && (idx == ch));
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw active-low button to clean level plus a one-cycle press pulse.
// Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic             level_q;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0  <= 1'b0;
      sync_1  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      sync_0  <= ~button_n;
      sync_1  <= sync_0;
      level_q <= level;
      if (sync_1 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= sync_1;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Rising edge of the accepted level only; releases stay silent.
  assign press = level & ~level_q;

endmodule

// File: rtl/led_sequencer.sv
// One-hot active-low LED sequencer with manual step, clear and timed auto-advance.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | all LEDs off, position held at 0
//   ST_RUN  | LED[position] lit, advances on step or tick
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned AUTO_PERIOD     = 12000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push_button0_n,
  input  logic                        push_button1_n,
  input  logic                        push_button2_n,
  output logic [NUM_LEDS-1:0]         led_n,
  output logic                        active,
  output logic [$clog2(NUM_LEDS)-1:0] position,
  output logic                        auto_mode
);

  localparam int unsigned POS_W  = pos_width(NUM_LEDS);
  localparam int unsigned TICK_W = cnt_width(AUTO_PERIOD);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_PERIOD - 1);

  logic [2:0]        unused_levels;
  logic              step_press;
  logic              clear_press;
  logic              toggle_press;

  seq_state_t        state;
  seq_state_t        nxt_state;
  logic [POS_W-1:0]  nxt_pos;
  logic              nxt_auto;
  logic [TICK_W-1:0] tick_count;
  logic [TICK_W-1:0] nxt_tick;
  logic              tick;
  logic              advance;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clock    (clock),
    .reset    (reset),
    .button_n (push_button0_n),
    .level    (unused_levels[0]),
    .press    (step_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock    (clock),
    .reset    (reset),
    .button_n (push_button1_n),
    .level    (unused_levels[1]),
    .press    (clear_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_toggle (
    .clock    (clock),
    .reset    (reset),
    .button_n (push_button2_n),
    .level    (unused_levels[2]),
    .press    (toggle_press)
  );

  assign tick    = auto_mode && (tick_count == TICK_LAST);
  // A step and a tick landing together still make a single advance.
  assign advance = step_press || tick;

  always_comb begin
    nxt_state = state;
    nxt_pos   = position;
    nxt_auto  = auto_mode;
    nxt_tick  = tick_count;
    if (clear_press) begin
      nxt_state = ST_IDLE;
      nxt_pos   = '0;
      nxt_auto  = 1'b0;
      nxt_tick  = '0;
    end else if (toggle_press) begin
      nxt_auto = ~auto_mode;
      nxt_tick = '0;
    end else begin
      if (!auto_mode || advance) begin
        nxt_tick = '0;
      end else begin
        nxt_tick = tick_count + TICK_W'(1);
      end
      if (advance) begin
        if (state == ST_IDLE) begin
          nxt_state = ST_RUN;
          nxt_pos   = '0;
        end else if (position == POS_LAST) begin
          nxt_pos = '0;
        end else begin
          nxt_pos = position + POS_W'(1);
        end
      end
    end
  end

  // Outputs are registered from the next-state values so they move with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      position   <= '0;
      auto_mode  <= 1'b0;
      tick_count <= '0;
      active     <= 1'b0;
      led_n      <= '1;
    end else begin
      state      <= nxt_state;
      position   <= nxt_pos;
      auto_mode  <= nxt_auto;
      tick_count <= nxt_tick;
      active     <= (nxt_state == ST_RUN);
      for (int ch = 0; ch < NUM_LEDS; ch++) begin
        led_n[ch] <= led_bit(nxt_state == ST_RUN, 32'(nxt_pos), unsigned'(ch));
      end
    end
  end

endmodule
